// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the MIPS front end.
// Holds fetch FSM states, the IF/ID bundle, word size and PC step.
package cpu_pkg;

  localparam int WORD = 32;

  localparam logic [WORD-1:0] PC_INC = 32'd4;

  localparam logic [WORD-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [WORD-1:0] instr;
    logic [WORD-1:0] pcplus4;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register, flush > stall > load > bubble.
// Ports: clk, rst_n, flush, stall, load, instr, pcplus4 in; q out.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [WORD-1:0] instr,
  input  logic [WORD-1:0] pcplus4,
  output if_id_t          q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      priority case (1'b1)
        flush: q.valid <= 1'b0;
        stall: q <= q;
        load: begin
          q.valid   <= 1'b1;
          q.instr   <= instr;
          q.pcplus4 <= pcplus4;
        end
        default: q.valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, fetch FSM, kill flag, hold buffer and IF/ID.
// Ports: imem req/addr/ack/data, stall, redirect(+Pc), ifid*, bubbleCount.
// Optional FETCH_BUBBLE_CNT_EN enables the saturating bubble counter.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imemReq,
  output logic [WORD-1:0] imemAddr,
  input  logic            imemAck,
  input  logic [WORD-1:0] imemData,
  input  logic            stall,
  input  logic            redirect,
  input  logic [WORD-1:0] redirectPc,
  output logic            ifidValid,
  output logic [WORD-1:0] ifidInstr,
  output logic [WORD-1:0] ifidPcPlus4,
  output logic [15:0]     ifidImm,
  output logic [WORD-1:0] bubbleCount
);

  fetch_state_t    state;
  logic [WORD-1:0] pc;
  logic [WORD-1:0] tgt;
  logic [WORD-1:0] hbuf;
  logic            kill;

  logic [WORD-1:0] rtgt;
  logic [WORD-1:0] pc4;
  logic            in_fetch;
  logic            in_hold;
  logic            take;
  logic            fload;
  logic            hload;
  logic            load;
  logic [WORD-1:0] ld_instr;
  if_id_t          ifid;

  assign rtgt     = redirectPc & ~32'h3;
  assign pc4      = pc + PC_INC;
  assign in_fetch = (state == FETCH);
  assign in_hold  = (state == HOLD);
  assign take     = in_fetch && imemAck;
  assign fload    = take && !redirect && !kill && !stall;
  assign hload    = in_hold && !redirect && !stall;
  assign load     = fload || hload;
  assign ld_instr = in_hold ? hbuf : imemData;

  assign imemReq  = in_fetch;
  assign imemAddr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      tgt   <= '0;
      hbuf  <= '0;
      kill  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= FETCH;
          if (redirect) pc <= rtgt;
        end
        FETCH: begin
          if (imemAck) begin
            if (redirect) begin
              pc   <= rtgt;
              kill <= 1'b0;
            end else if (kill) begin
              pc   <= tgt;
              kill <= 1'b0;
            end else if (stall) begin
              hbuf  <= imemData;
              state <= HOLD;
            end else begin
              pc <= pc4;
            end
          end else if (redirect) begin
            // request stays on the bus; its data is dropped at ack
            kill <= 1'b1;
            tgt  <= rtgt;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= rtgt;
            state <= FETCH;
          end else if (!stall) begin
            pc    <= pc4;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect),
    .stall   (stall),
    .load    (load),
    .instr   (ld_instr),
    .pcplus4 (pc4),
    .q       (ifid)
  );

  assign ifidValid   = ifid.valid;
  assign ifidInstr   = ifid.instr;
  assign ifidPcPlus4 = ifid.pcplus4;
  assign ifidImm     = ifid.instr[15:0];

`ifdef FETCH_BUBBLE_CNT_EN
  logic [WORD-1:0] bcnt;
  logic            nvalid;

  // mirrors if_id_reg priority: value of valid after this edge
  assign nvalid = redirect ? 1'b0 :
                  stall    ? ifid.valid : load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
    end else if (!nvalid && bcnt != 32'hFFFF_FFFF) begin
      bcnt <= bcnt + 32'd1;
    end
  end

  assign bubbleCount = bcnt;
`else
  assign bubbleCount = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors, queue scoreboard, negedge monitor.
// Memory returns addr ^ 32'hA5A5; ack is driven per cycle.
module tb_fetch_stage;

  localparam logic [31:0] A0 = 32'h0040_0000;
`ifdef FETCH_BUBBLE_CNT_EN
  localparam logic [31:0] BDELTA = 32'd1;
`else
  localparam logic [31:0] BDELTA = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        ifidValid;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPcPlus4;
  logic [15:0] ifidImm;
  logic [31:0] bubbleCount;

  fetch_stage #(.RESET_PC(A0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemAck     (imemAck),
    .imemData    (imemData),
    .stall       (stall),
    .redirect    (redirect),
    .redirectPc  (redirectPc),
    .ifidValid   (ifidValid),
    .ifidInstr   (ifidInstr),
    .ifidPcPlus4 (ifidPcPlus4),
    .ifidImm     (ifidImm),
    .bubbleCount (bubbleCount)
  );

  always #5 clk = ~clk;

  assign imemData = imemAddr ^ 32'h0000_A5A5;

  logic [31:0] reqq[$];
  logic [31:0] ifq[$];
  int          total = 0;
  int          bad = 0;
  int          tag = 0;
  logic [31:0] b0 = '0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (tag == 1) begin
      chk("rst_req", {31'd0, imemReq}, 32'd0);
      chk("rst_addr", imemAddr, A0);
      chk("rst_valid", {31'd0, ifidValid}, 32'd0);
      chk("rst_instr", ifidInstr, 32'd0);
      chk("rst_pc4", ifidPcPlus4, 32'd0);
      chk("rst_imm", {16'd0, ifidImm}, 32'd0);
      chk("rst_bcnt", bubbleCount, 32'd0);
    end
    if (tag == 4) begin
      chk("reqq_left", reqq.size(), 32'd0);
      chk("ifq_left", ifq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (rst_n) begin
      if (imemReq) begin
        if (reqq.size() == 0) begin
          chk("req_extra", imemAddr, 32'hDEAD_BEEF);
        end else begin
          e = reqq.pop_front();
          chk("req_addr", imemAddr, e);
        end
      end
      if (ifidValid) begin
        if (ifq.size() == 0) begin
          chk("ifid_extra", ifidPcPlus4, 32'hDEAD_BEEF);
        end else begin
          e = ifq.pop_front();
          chk("ifid_instr", ifidInstr, e ^ 32'h0000_A5A5);
          chk("ifid_pc4", ifidPcPlus4, e + 32'd4);
          chk("ifid_imm", {16'd0, ifidImm},
              {16'd0, e[15:0] ^ 16'hA5A5});
        end
      end
    end
    if (tag == 2) b0 = bubbleCount;
    if (tag == 3) begin
      chk("bcnt_delta", bubbleCount - b0, BDELTA);
`ifndef FETCH_BUBBLE_CNT_EN
      chk("bcnt_zero", bubbleCount, 32'd0);
`endif
    end
  end

  task automatic step(input logic a, input logic s, input logic r,
                      input logic [31:0] t);
    imemAck    = a;
    stall      = s;
    redirect   = r;
    redirectPc = t;
    @(posedge clk);
    #1;
    tag = 0;
  endtask

  task automatic xr(input logic [31:0] a);
    reqq.push_back(a);
  endtask

  task automatic xi(input logic [31:0] a);
    ifq.push_back(a);
  endtask

  initial begin
    rst_n      = 1'b0;
    imemAck    = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    redirectPc = '0;
    @(posedge clk);
    #1;
    tag = 1;
    @(posedge clk);
    #1;
    tag   = 0;
    rst_n = 1'b1;
    // c1 idle
    step(1, 0, 0, 0);
    // c2 first request
    xr(A0);
    step(1, 0, 0, 0);
    // c3
    xr(A0 + 32'h4); xi(A0);
    step(1, 0, 0, 0);
    // c4 stall during ack of +8
    xr(A0 + 32'h8); xi(A0 + 32'h4);
    step(1, 1, 0, 0);
    // c5, c6 hold
    xi(A0 + 32'h4);
    step(1, 1, 0, 0);
    xi(A0 + 32'h4);
    step(1, 1, 0, 0);
    // c7 stall drops
    xi(A0 + 32'h4);
    step(1, 0, 0, 0);
    // c8
    xr(A0 + 32'hC); xi(A0 + 32'h8);
    step(1, 0, 0, 0);
    // c9 redirect with ack
    tag = 2;
    xr(A0 + 32'h10); xi(A0 + 32'hC);
    step(1, 0, 1, A0 + 32'h100);
    // c10 flushed
    xr(A0 + 32'h100);
    step(1, 0, 0, 0);
    // c11 slow memory, redirect in wait 1
    tag = 3;
    xr(A0 + 32'h104); xi(A0 + 32'h100);
    step(0, 0, 1, A0 + 32'h200);
    // c12 wait 2
    xr(A0 + 32'h104);
    step(0, 0, 0, 0);
    // c13 late ack, killed
    xr(A0 + 32'h104);
    step(1, 0, 0, 0);
    // c14
    xr(A0 + 32'h200);
    step(1, 0, 0, 0);
    // c15 stall into hold
    xr(A0 + 32'h204); xi(A0 + 32'h200);
    step(1, 1, 0, 0);
    // c16 redirect+stall in hold, unaligned target
    xi(A0 + 32'h200);
    step(1, 1, 1, A0 + 32'h103);
    // c17
    xr(A0 + 32'h100);
    step(1, 0, 0, 0);
    // c18 no ack
    xr(A0 + 32'h104); xi(A0 + 32'h100);
    step(0, 0, 0, 0);
    // c19 reset mid-wait
    rst_n   = 1'b0;
    imemAck = 1'b0;
    tag     = 1;
    @(posedge clk);
    #1;
    tag   = 0;
    rst_n = 1'b1;
    // c20 late ack in idle
    step(1, 0, 0, 0);
    // c21
    xr(A0);
    step(1, 0, 0, 0);
    // c22 redirect to top of memory
    xr(A0 + 32'h4); xi(A0);
    step(1, 0, 1, 32'hFFFF_FFFC);
    // c23
    xr(32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    // c24 wrapped
    xr(32'h0); xi(32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    // c25
    xr(32'h0);
    step(0, 0, 0, 0);
    tag = 4;
    repeat (5) @(posedge clk);
    $display("FAIL end_timeout: monitor never finished");
    $fatal(1);
  end

endmodule
